nox_uart_rx: RTL and testbench

// - Receive path paired with the SoC UART transmitter; drives the uart_rx_i pin currently tied to '1.
// - Deserialises 8N1 frames (1 start, 8 data LSB-first, 1 stop) from an asynchronous line.
// - Buffers bytes in a small FIFO behind a valid/ready stream toward the AXI UART wrapper's RX register.
// - Flags frame errors and overruns for software.

---
 rtl/utils_pkg.sv | 14 +
 rtl/nox_rx_fifo.sv | 60 ++++++
 rtl/nox_uart_rx.sv | 134 +++++++++++++
 tb/tb_nox_uart_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// Shared UART types and constants used by the receive path and its FIFO.
package utils_pkg;

  localparam int UART_MIN_DIV = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uart_rx_st_t;

endpackage

// File: rtl/nox_rx_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on rdata while not empty.
module nox_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      level_q;
  logic             push_ok, pop_ok;

  assign full  = (level_q == LVL_MAX);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/nox_uart_rx.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM, sticky error flags and an RX FIFO.
module nox_uart_rx
  import utils_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [15:0]                   baud_div_i,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          busy_o,
  output logic                          frame_err_o,
  output logic                          overrun_o,
  input  logic                          clr_err_i
);

  localparam logic [15:0] MIN_DIV = 16'(UART_MIN_DIV);
  localparam logic [15:0] CNT_ONE = 16'd1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_s_q;
  uart_rx_st_t            state;
  logic [15:0]            bit_cnt, div, half;
  logic [2:0]             idx;
  logic [7:0]             shreg;
  logic                   bit_tick, push, ferr_set, ovr_set;
  logic                   fifo_full, fifo_empty, pop;
  logic                   frame_err_q, overrun_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q <= '1;
      rx_s_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_s_q <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  assign div      = (baud_div_i < MIN_DIV) ? MIN_DIV : baud_div_i;
  assign half     = div >> 1;
  assign bit_tick = (bit_cnt == '0);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= RX_IDLE;
      bit_cnt <= '0;
      idx     <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (rx_s_q && !rx_s) begin
            bit_cnt <= half - CNT_ONE;
            state   <= RX_START;
          end
        end
        RX_START: begin
          if (!bit_tick) begin
            bit_cnt <= bit_cnt - CNT_ONE;
          end else if (rx_s) begin
            state <= RX_IDLE;
          end else begin
            bit_cnt <= div - CNT_ONE;
            idx     <= '0;
            state   <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (!bit_tick) begin
            bit_cnt <= bit_cnt - CNT_ONE;
          end else begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= div - CNT_ONE;
            idx     <= idx + 3'd1;
            if (idx == 3'd7) state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (!bit_tick) bit_cnt <= bit_cnt - CNT_ONE;
          else           state   <= rx_s ? RX_IDLE : RX_BREAK;
        end
        // Stay here until the line returns high so a held break flags only once.
        RX_BREAK: begin
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign push     = (state == RX_STOP) && bit_tick &&  rx_s;
  assign ferr_set = (state == RX_STOP) && bit_tick && !rx_s;
  assign pop      = rx_ready_i & rx_valid_o;
  assign ovr_set  = push & fifo_full & ~pop;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_set | (frame_err_q & ~clr_err_i);
      overrun_q   <= ovr_set  | (overrun_q   & ~clr_err_i);
    end
  end

  nox_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .arst  (arst),
    .push  (push),
    .wdata (shreg),
    .pop   (pop),
    .rdata (rx_data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level_o)
  );

  assign rx_valid_o  = ~fifo_empty;
  assign busy_o      = (state != RX_IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_nox_uart_rx.sv
// Randomised 8N1 stimulus with a byte scoreboard popped by an independent output monitor.
module tb_nox_uart_rx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        arst;
  logic [15:0] baud_div;
  logic        rx, rdy, clr;
  logic [7:0]  rx_data;
  logic        rx_valid, busy, ferr, ovr;
  logic [3:0]  level;

  logic [7:0]  exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          exp_ovr = 1'b0;
  bit          exp_ferr = 1'b0;

  nox_uart_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .arst         (arst),
    .baud_div_i   (baud_div),
    .rx_i         (rx),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .rx_ready_i   (rdy),
    .fifo_level_o (level),
    .busy_o       (busy),
    .frame_err_o  (ferr),
    .overrun_o    (ovr),
    .clr_err_i    (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Output side: every accepted handshake must match the oldest expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rx_valid && rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_byte: got %02h, expected none", rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", rx_data, e);
        end
      end
    end
  end

  // Reference behaviour decided when the stop bit goes on the wire.
  task automatic model_stop(input logic [7:0] b, input logic stop, input bit coincide);
    if (!stop)                                   exp_ferr = 1'b1;
    else if (exp_q.size() < DEPTH || coincide)   exp_q.push_back(b);
    else                                         exp_ovr = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bitlen, input bit coincide);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == 9) model_stop(b, stop, coincide);
      rx = fr[i];
      tick(bitlen);
    end
    rx = 1'b1;
    tick(bitlen);
  endtask

  function automatic int eff_div(input int d);
    return (d < 8) ? 8 : d;
  endfunction

  // Frame plus a check that rx_valid rises on the cycle after the mid-stop sample.
  task automatic send_checked(input logic [7:0] b, input int d);
    int bl;
    bl = eff_div(d);
    baud_div = 16'(d);
    fork
      send_frame(b, 1'b1, bl, 1'b0);
      begin
        tick(2 + bl / 2 + 9 * bl);
        chk("valid_before_stop", rx_valid, 1'b0);
        tick(1);
        chk("valid_after_stop", rx_valid, 1'b1);
      end
    join
  endtask

  task automatic drain();
    int t;
    t = 0;
    rdy = 1'b1;
    while (exp_q.size() != 0 && t < 4000) begin tick(1); t++; end
    tick(2);
    chk("drain_done", 32'(exp_q.size()), 0);
    chk("drain_level", level, 0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; tick(1); clr = 1'b0;
    exp_ferr = 1'b0; exp_ovr = 1'b0;
  endtask

  task automatic check_flags(input string nm);
    chk({nm, "_frame_err"}, ferr, exp_ferr);
    chk({nm, "_overrun"}, ovr, exp_ovr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int d;
    arst = 1'b1; rx = 1'b1; rdy = 1'b1; clr = 1'b0; baud_div = 16'd16;
    tick(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    check_flags("rst");
    arst = 1'b0;
    tick(4);

    // Basic frame at 16 clocks per bit.
    send_checked(8'hA5, 16);
    drain();
    check_flags("basic");

    // Glitch shorter than half a bit.
    baud_div = 16'd16;
    rx = 1'b0; tick(5);
    chk("glitch_busy_mid", busy, 1);
    rx = 1'b1; tick(40);
    chk("glitch_busy", busy, 0);
    chk("glitch_level", level, 0);
    check_flags("glitch");

    // Framing error, then recovery with a good byte held in the FIFO.
    rdy = 1'b0;
    send_frame(8'h3C, 1'b0, 16, 1'b0);
    tick(16);
    send_frame(8'h55, 1'b1, 16, 1'b0);
    check_flags("ferr");
    chk("ferr_level", level, 1);
    chk("ferr_head", rx_data, 8'h55);
    drain();
    pulse_clr();
    check_flags("ferr_clr");

    // Held-low break yields exactly one frame error.
    baud_div = 16'd8;
    rx = 1'b0; tick(200);
    chk("break_ferr", ferr, 1);
    clr = 1'b1; tick(1); clr = 1'b0;
    tick(100);
    chk("break_once", ferr, 0);
    chk("break_busy", busy, 1);
    rx = 1'b1; tick(20);
    chk("break_idle", busy, 0);

    // Overrun: nine bytes into eight slots with no reader.
    rdy = 1'b0;
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 8, 1'b0);
    chk("ovr_level", level, DEPTH);
    check_flags("ovr");
    drain();
    pulse_clr();
    check_flags("ovr_clr");

    // Push at full with a pop on the very same edge.
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b1, 8, 1'b0);
    b = 8'($urandom);
    fork
      send_frame(b, 1'b1, 8, 1'b1);
      begin
        tick(2 + 4 + 9 * 8);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
      end
    join
    chk("simul_level", level, DEPTH);
    check_flags("simul");
    drain();

    // Divider below the minimum behaves as 8.
    send_checked(8'($urandom), 3);
    send_checked(8'($urandom), 0);
    drain();

    // Random bytes at random dividers.
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(3, 24);
      baud_div = 16'(d);
      send_frame(8'($urandom), 1'b1, eff_div(d), 1'b0);
    end
    drain();
    check_flags("rand");

    // Reset mid-frame with a byte pending and a frame error latched.
    baud_div = 16'd16;
    rdy = 1'b0;
    send_frame(8'h42, 1'b1, 16, 1'b0);
    send_frame(8'h11, 1'b0, 16, 1'b0);
    chk("pre_rst_valid", rx_valid, 1);
    chk("pre_rst_ferr", ferr, 1);
    b = 8'h77;
    rx = 1'b0; tick(16);
    for (int i = 0; i < 4; i++) begin rx = b[i]; tick(16); end
    rx = b[4]; tick(8);
    chk("mid_busy", busy, 1);
    arst = 1'b1;
    #1;
    exp_q.delete(); exp_ferr = 1'b0; exp_ovr = 1'b0;
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    check_flags("mid_rst");
    rx = 1'b1;
    tick(3);
    arst = 1'b0;
    tick(3);
    chk("post_rst_level", level, 0);
    rdy = 1'b1;
    send_checked(8'h81, 16);
    drain();
    check_flags("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
